// File: rtl/xl320_poll_scheduler.sv
// Avalon-MM master for the XL320 servo bridge: pushes pending goal-position
// writes ahead of a periodic round-robin PRESENT_POSITION sweep and caches results.
module xl320_poll_scheduler #(
  parameter int NUMBER_OF_MOTORS = 4,
  parameter int POLL_PERIOD      = 50000,
  parameter int READ_INSTR       = 69,
  parameter int WRITE_INSTR      = 70,
  parameter int GOAL_REG         = 30,
  parameter int PRESENT_REG      = 37
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        goal_write,
  input  logic [7:0]  goal_id,
  input  logic [15:0] goal_value,
  input  logic [7:0]  pos_id,
  output logic [15:0] pos_value,
  output logic        sweep_done,
  output logic [15:0] xl_address,
  output logic        xl_write,
  output logic [31:0] xl_writedata,
  output logic        xl_read,
  input  logic [31:0] xl_readdata,
  input  logic        xl_waitrequest
);

  localparam int unsigned IDX_W = (NUMBER_OF_MOTORS > 1) ? $clog2(NUMBER_OF_MOTORS) : 1;
  localparam int unsigned TMR_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [7:0]       NUM_ID   = 8'(NUMBER_OF_MOTORS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBER_OF_MOTORS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, NEXT} state_t;

  state_t                      state, state_nxt;
  logic [15:0]                 goal [NUMBER_OF_MOTORS];
  logic [15:0]                 pos  [NUMBER_OF_MOTORS];
  logic [NUMBER_OF_MOTORS-1:0] dirty;
  logic [IDX_W-1:0]            cursor;
  logic [IDX_W-1:0]            wr_idx;
  logic [TMR_W-1:0]            timer;
  logic                        poll_pending;
  logic                        sweep_active;

  logic                        any_dirty, goal_hit, timer_wrap;
  logic [IDX_W-1:0]            low_idx, goal_idx;
  logic                        write_nxt, read_nxt, done_nxt;
  logic [15:0]                 address_nxt;
  logic [31:0]                 writedata_nxt;
  logic                        issue_write, start_sweep, write_done, read_done, last_step;

  // Upper read-data bits and the PRESENT_POSITION address are not needed by this master.
  logic unused_ok;
  assign unused_ok = ^{xl_readdata[31:16], 16'(PRESENT_REG)};

  assign goal_hit   = goal_write && (goal_id < NUM_ID);
  assign goal_idx   = goal_id[IDX_W-1:0];
  assign timer_wrap = enable && (timer == TMR_LAST);
  assign last_step  = (state == NEXT) && (cursor == LAST_IDX);

  // Lowest dirty motor wins the next write slot.
  always_comb begin
    any_dirty = 1'b0;
    low_idx   = '0;
    for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
      if (dirty[i] && !any_dirty) begin
        any_dirty = 1'b1;
        low_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    write_nxt     = 1'b0;
    read_nxt      = 1'b0;
    done_nxt      = 1'b0;
    address_nxt   = xl_address;
    writedata_nxt = xl_writedata;
    issue_write   = 1'b0;
    start_sweep   = 1'b0;
    write_done    = 1'b0;
    read_done     = 1'b0;
    case (state)
      IDLE: begin
        if (any_dirty) begin
          state_nxt     = WRITE;
          write_nxt     = 1'b1;
          issue_write   = 1'b1;
          address_nxt   = {8'(WRITE_INSTR), 8'(low_idx)};
          writedata_nxt = {16'(GOAL_REG), goal[low_idx]};
        end else if (sweep_active || (poll_pending && enable)) begin
          state_nxt     = READ;
          read_nxt      = 1'b1;
          start_sweep   = !sweep_active;
          address_nxt   = {8'(READ_INSTR), 8'(cursor)};
          writedata_nxt = '0;
        end
      end
      WRITE: begin
        if (xl_waitrequest) begin
          write_nxt = 1'b1;
        end else begin
          write_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      READ: begin
        if (xl_waitrequest) begin
          read_nxt = 1'b1;
        end else begin
          read_done = 1'b1;
          state_nxt = NEXT;
        end
      end
      NEXT: begin
        state_nxt = IDLE;
        done_nxt  = (cursor == LAST_IDX);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and registered bus outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      xl_write     <= 1'b0;
      xl_read      <= 1'b0;
      xl_address   <= '0;
      xl_writedata <= '0;
      sweep_done   <= 1'b0;
      wr_idx       <= '0;
    end else begin
      state        <= state_nxt;
      xl_write     <= write_nxt;
      xl_read      <= read_nxt;
      xl_address   <= address_nxt;
      xl_writedata <= writedata_nxt;
      sweep_done   <= done_nxt;
      if (issue_write) wr_idx <= low_idx;
    end
  end

  // Poll timer; a tick coinciding with sweep start re-arms poll_pending.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer        <= '0;
      poll_pending <= 1'b0;
      sweep_active <= 1'b0;
      cursor       <= '0;
    end else begin
      if (enable) timer <= (timer == TMR_LAST) ? '0 : timer + 1'b1;
      if (start_sweep) poll_pending <= 1'b0;
      if (timer_wrap) poll_pending <= 1'b1;
      if (start_sweep) sweep_active <= 1'b1;
      if (last_step) sweep_active <= 1'b0;
      if (state == NEXT) cursor <= (cursor == LAST_IDX) ? '0 : cursor + 1'b1;
    end
  end

  // Goal/dirty capture; a goal landing on its own completion cycle keeps dirty set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dirty <= '0;
      for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
        goal[i] <= '0;
        pos[i]  <= '0;
      end
      pos_value <= '0;
    end else begin
      if (write_done) dirty[wr_idx] <= 1'b0;
      if (goal_hit) begin
        dirty[goal_idx] <= 1'b1;
        goal[goal_idx]  <= goal_value;
      end
      if (read_done) pos[cursor] <= xl_readdata[15:0];
      pos_value <= (pos_id < NUM_ID) ? pos[pos_id[IDX_W-1:0]] : '0;
    end
  end

endmodule

// File: tb/tb_xl320_poll_scheduler.sv
// Directed bench for xl320_poll_scheduler with a wait-state XL320 slave model.
module tb_xl320_poll_scheduler;

  localparam int NM = 4;
  localparam int PP = 100;

  logic        clock = 1'b0;
  logic        reset, enable, goal_write;
  logic [7:0]  goal_id, pos_id;
  logic [15:0] goal_value, pos_value, xl_address;
  logic        sweep_done, xl_write, xl_read, xl_waitrequest;
  logic [31:0] xl_writedata, xl_readdata;

  xl320_poll_scheduler #(.NUMBER_OF_MOTORS(NM), .POLL_PERIOD(PP)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .goal_write(goal_write), .goal_id(goal_id), .goal_value(goal_value),
    .pos_id(pos_id), .pos_value(pos_value), .sweep_done(sweep_done),
    .xl_address(xl_address), .xl_write(xl_write), .xl_writedata(xl_writedata),
    .xl_read(xl_read), .xl_readdata(xl_readdata), .xl_waitrequest(xl_waitrequest)
  );

  always #5 clock = ~clock;

  // Slave: stalls wait_cycles cycles per request (or indefinitely under force_wait).
  int   wait_cycles = 0;
  logic force_wait  = 1'b0;
  int   cnt = 0;
  always @(posedge clock) cnt <= (xl_read || xl_write) ? cnt + 1 : 0;
  assign xl_waitrequest = force_wait || (cnt < wait_cycles);
  assign xl_readdata    = 32'd100 + {24'h0, xl_address[7:0]};

  typedef struct packed {logic wr; logic [15:0] addr; logic [31:0] data;} txn_t;
  txn_t log_q[$];
  int   req_cycles = 0, done_pulses = 0, both_high = 0, no_gap = 0;
  logic prev_done = 1'b0;

  // Bus monitor, sampled mid-low-phase after the bench has driven its inputs.
  always begin
    @(negedge clock);
    #2;
    if (xl_read && xl_write) both_high++;
    if ((xl_read || xl_write) && prev_done) no_gap++;
    if (xl_read || xl_write) req_cycles++;
    if (sweep_done) done_pulses++;
    prev_done = (xl_read || xl_write) && !xl_waitrequest && !reset;
    if (prev_done) log_q.push_back('{xl_write, xl_address, xl_read ? xl_readdata : xl_writedata});
  end

  int n_tests = 0, n_fail = 0;
  int k, held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_goal(input logic [7:0] id, input logic [15:0] v);
    goal_write = 1'b1; goal_id = id; goal_value = v;
    @(negedge clock);
    goal_write = 1'b0;
  endtask

  task automatic clear_log();
    log_q.delete();
    req_cycles  = 0;
    done_pulses = 0;
  endtask

  task automatic wait_sweep(input string tag);
    k = 0;
    while (!sweep_done && k < 400) begin @(negedge clock); k++; end
    check(tag, 32'(k < 400), 32'd1);
  endtask

  function automatic logic [31:0] log_field(input int i, input int sel);
    if (i >= log_q.size()) return 32'hDEAD_BEEF;
    case (sel)
      0:       return 32'(log_q[i].wr);
      1:       return 32'(log_q[i].addr);
      default: return log_q[i].data;
    endcase
  endfunction

  logic [15:0] exp_addr [5];
  logic [31:0] exp_data [5];
  logic        exp_wr   [5];

  initial begin
    reset = 1'b1; enable = 1'b0; goal_write = 1'b0; goal_id = '0;
    goal_value = '0; pos_id = 8'd0;
    tick(3);
    check("rst_read",      32'(xl_read),      32'd0);
    check("rst_write",     32'(xl_write),     32'd0);
    check("rst_address",   32'(xl_address),   32'd0);
    check("rst_writedata", xl_writedata,      32'd0);
    check("rst_sweep",     32'(sweep_done),   32'd0);
    check("rst_pos",       32'(pos_value),    32'd0);
    reset = 1'b0;
    clear_log();

    // Idle with polling disabled: bus stays quiet.
    tick(1000);
    check("idle_req_cycles", 32'(req_cycles),  32'd0);
    check("idle_sweeps",     32'(done_pulses), 32'd0);
    check("idle_pos",        32'(pos_value),   32'd0);

    // Goal write held under a 20-cycle stall.
    force_wait = 1'b1;
    pulse_goal(8'd0, 16'd1023);
    held = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (xl_write && !xl_read && xl_address == 16'h4600 && xl_writedata == 32'h001E03FF) held++;
    end
    check("wr_hold_cycles", 32'(held), 32'd20);
    force_wait = 1'b0;
    @(negedge clock);
    check("wr_drop", 32'(xl_write), 32'd0);
    tick(10);
    check("wr_count", 32'(log_q.size()), 32'd1);
    check("wr_addr",  log_field(0, 1), 32'h4600);
    check("wr_data",  log_field(0, 2), 32'h001E03FF);
    pulse_goal(8'd4, 16'd5);
    pulse_goal(8'd255, 16'd6);
    tick(20);
    check("oob_goal_ignored", 32'(log_q.size()), 32'd1);

    // First sweep: reads 0..3 in order, then sweep_done.
    clear_log();
    wait_cycles = 5;
    enable = 1'b1;
    wait_sweep("sweep1_timeout");
    check("sweep1_len", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < NM; i++) begin
      check($sformatf("sweep1_wr%0d", i),   log_field(i, 0), 32'd0);
      check($sformatf("sweep1_addr%0d", i), log_field(i, 1), 32'h4500 + 32'(i));
      check($sformatf("sweep1_data%0d", i), log_field(i, 2), 32'd100 + 32'(i));
    end
    pos_id = 8'd2; tick(2);
    check("pos2", 32'(pos_value), 32'd102);
    pos_id = 8'd0; tick(2);
    check("pos0", 32'(pos_value), 32'd100);
    pos_id = 8'd4; tick(2);
    check("pos_oob", 32'(pos_value), 32'd0);
    check("sweep1_pulses", 32'(done_pulses), 32'd1);

    // Goal write interleaves between the reads of motors 2 and 3.
    clear_log();
    k = 0;
    while (!(xl_read && xl_address == 16'h4502) && k < 400) begin @(negedge clock); k++; end
    check("rd2_timeout", 32'(k < 400), 32'd1);
    pulse_goal(8'd1, 16'd500);
    wait_sweep("sweep2_timeout");
    enable = 1'b0;
    exp_addr = '{16'h4500, 16'h4501, 16'h4502, 16'h4601, 16'h4503};
    exp_wr   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_data = '{32'd100, 32'd101, 32'd102, 32'h001E01F4, 32'd103};
    check("sweep2_len", 32'(log_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("sweep2_wr%0d", i),   log_field(i, 0), 32'(exp_wr[i]));
      check($sformatf("sweep2_addr%0d", i), log_field(i, 1), 32'(exp_addr[i]));
      check($sformatf("sweep2_data%0d", i), log_field(i, 2), exp_data[i]);
    end

    // New goal on the completion cycle of the same motor's write forces a resend.
    tick(3);
    clear_log();
    wait_cycles = 2;
    pulse_goal(8'd3, 16'd10);
    k = 0;
    while (!(xl_write && !xl_waitrequest) && k < 50) begin @(negedge clock); k++; end
    check("wr3_timeout", 32'(k < 50), 32'd1);
    pulse_goal(8'd3, 16'd20);
    tick(40);
    check("resend_len",   32'(log_q.size()), 32'd2);
    check("resend_data0", log_field(0, 2), 32'h001E000A);
    check("resend_addr1", log_field(1, 1), 32'h4603);
    check("resend_data1", log_field(1, 2), 32'h001E0014);

    // Reset in the middle of a stalled read.
    clear_log();
    wait_cycles = 0;
    force_wait = 1'b1;
    enable = 1'b1;
    pos_id = 8'd2;
    k = 0;
    while (!xl_read && k < 300) begin @(negedge clock); k++; end
    check("rd_rst_timeout", 32'(k < 300), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_read",    32'(xl_read),    32'd0);
    check("rst_mid_address", 32'(xl_address), 32'd0);
    check("rst_mid_pos",     32'(pos_value),  32'd0);
    tick(2);
    reset = 1'b0;
    force_wait = 1'b0;
    clear_log();
    wait_sweep("sweep3_timeout");
    check("sweep3_len",   32'(log_q.size()), 32'd4);
    check("sweep3_first", log_field(0, 1), 32'h4500);
    tick(2);
    check("sweep3_pos2", 32'(pos_value), 32'd102);

    check("bus_both_high", 32'(both_high), 32'd0);
    check("bus_no_gap",    32'(no_gap),    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xl320_poll_scheduler.md
Name: xl320_poll_scheduler

Overview:
- Avalon-MM master that sequences the XL320 half-duplex servo bridge for up to NUMBER_OF_MOTORS Dynamixel XL320 motors.
- Pushes pending goal-position writes with priority over polling.
- Runs a periodic round-robin sweep that reads PRESENT_POSITION of every motor and caches the results for upstream logic.
- Sits between the robot control registers and the XL320 slave; it is the XL320's only master.

Parameters:
- NUMBER_OF_MOTORS, 4: motors addressed; IDs 0..NUMBER_OF_MOTORS-1.
- POLL_PERIOD, 50000: clocks between sweep starts.
- READ_INSTR, 69: instruction byte for address[15:8] on reads.
- WRITE_INSTR, 70: instruction byte for address[15:8] on writes.
- GOAL_REG, 30: control-table address of GOAL_POSITION.
- PRESENT_REG, 37: control-table address of PRESENT_POSITION.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  polling enable; goal writes are serviced regardless.
- goal_write  in  1  single-cycle strobe that latches a new goal.
- goal_id  in  8  motor ID for goal_write.
- goal_value  in  16  goal position, 0..1023.
- pos_id  in  8  selects a cached position.
- pos_value  out  16  registered cached PRESENT_POSITION of pos_id.
- sweep_done  out  1  one-cycle pulse when a full sweep completes.
- xl_address  out  16  {instruction, motor ID} to the XL320.
- xl_write  out  1  Avalon write.
- xl_writedata  out  32  {register address[15:0], value[15:0]}.
- xl_read  out  1  Avalon read.
- xl_readdata  in  32  XL320 read data; valid in the cycle xl_read=1 and xl_waitrequest=0.
- xl_waitrequest  in  1  XL320 stall.

Behaviour:
- Reset:
  - All outputs 0.
  - FSM in IDLE; goal/dirty/position arrays cleared.
  - Poll timer 0; poll_pending 0; sweep cursor 0.
  - Reset asserted mid-transaction drops xl_read/xl_write immediately, with no completion.
- Goal capture:
  - On goal_write with goal_id < NUMBER_OF_MOTORS: goal[goal_id] <= goal_value and dirty[goal_id] <= 1.
  - goal_write with goal_id out of range is ignored.
- Poll timer:
  - Counts only while enable=1; holds its value when enable=0.
  - At POLL_PERIOD-1 it wraps to 0 and sets poll_pending.
  - A tick while poll_pending is already set is dropped; sweeps never queue.
- FSM states: IDLE, WRITE, READ, NEXT.
- IDLE (priority order):
  1. If any dirty bit is set, the lowest set index i wins. Next cycle: xl_address={WRITE_INSTR,i}, xl_writedata={GOAL_REG,goal[i]}, xl_write=1. Go to WRITE.
  2. Else if a sweep is in progress, or poll_pending=1 and enable=1: clear poll_pending when starting a new sweep. Next cycle: xl_address={READ_INSTR,cursor}, xl_writedata=0, xl_read=1. Go to READ.
  3. Else stay in IDLE.
- WRITE:
  - Hold address, data and xl_write until a cycle with xl_waitrequest=0, then deassert and return to IDLE.
  - writedata is frozen at issue.
  - On completion, dirty[i] is cleared unless goal_write to i occurs in that same cycle. In that case dirty stays 1 and the new value is re-sent.
- READ:
  - Hold until xl_waitrequest=0; in that cycle pos[cursor] <= xl_readdata[15:0]. Deassert xl_read and go to NEXT.
- NEXT:
  - If cursor = NUMBER_OF_MOTORS-1: cursor <= 0, pulse sweep_done, end the sweep.
  - Else cursor++.
  - Always go to IDLE, so pending goal writes interleave between sweep reads.
  - If enable drops mid-sweep, the sweep still finishes.
- Bus rules:
  - xl_read and xl_write are never both 1.
  - At least one idle bus cycle between transactions.
- pos_value:
  - pos_value <= pos[pos_id] each clock (1-cycle latency).
  - pos_id out of range returns 0.
- Minimum cycles per read with zero wait: issue 1 + READ 1 + NEXT 1 (+ IDLE 1).

Test Plan:
- Reset then idle, enable=0 → xl_read=xl_write=0 for 1000 cycles; pos_value=0; sweep_done never pulses.
- goal_write id=0 value=1023 with waitrequest=1 for 20 cycles → xl_address=0x4600 and xl_writedata=0x001E03FF held for 20 cycles, drop 1 cycle after waitrequest falls; exactly one write.
- POLL_PERIOD=100, 4 motors, enable=1; model returns 100+id with 5-cycle waitrequest → reads to 0x4500..0x4503 in order, then sweep_done pulse; pos_id=2 gives pos_value=102.
- goal_write id=1 value=500 during the read of motor 2 → after that read: write 0x4601 with data 0x001E01F4, then read of motor 3; sweep completes normally.
- goal_write id=3 value=10 issued, then goal_write id=3 value=20 on that write's completion cycle → second write 0x4603 with data 0x001E0014 follows; dirty clears afterwards.
- Assert reset mid-READ with waitrequest=1 → xl_read=0 at once; positions 0; after release the first sweep starts at motor 0.
